// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b LSB-first through one full-adder cell (a + ~b + 1).
// Uses a start/busy/done handshake and reports difference, borrow, signed overflow and zero flags.
`timescale 1ns/1ps
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] diff_d;
  logic             borrow_d, overflow_d, zero_d, busy_d, done_d;

  // Full-adder cell on the current LSBs; the result register fills from the MSB side.
  logic             sum_bit, carry_out;
  logic [WIDTH-1:0] r_shift;

  assign sum_bit   = sa_q[0] ^ sb_q[0] ^ carry_q;
  assign carry_out = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q) | (sb_q[0] & carry_q);
  assign r_shift   = {sum_bit, r_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      r_q      <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      r_q      <= r_d;
      carry_q  <= carry_d;
      count_q  <= count_d;
      diff     <= diff_d;
      borrow   <= borrow_d;
      overflow <= overflow_d;
      zero     <= zero_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // Next-state and datapath; carry_q on the final edge is the carry into the MSB.
  always_comb begin
    state_d    = state_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    r_d        = r_q;
    carry_d    = carry_q;
    count_d    = count_q;
    diff_d     = diff;
    borrow_d   = borrow;
    overflow_d = overflow;
    zero_d     = zero;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = ~b;
          carry_d = 1'b1;
          count_d = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        busy_d  = 1'b1;
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        r_d     = r_shift;
        carry_d = carry_out;
        count_d = CW'(count_q + CW'(1));
        if (count_q == CW'(WIDTH - 1)) begin
          state_d    = DONE;
          done_d     = 1'b1;
          diff_d     = r_shift;
          borrow_d   = ~carry_out;
          overflow_d = carry_q ^ carry_out;
          zero_d     = (r_shift == '0);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus random operands
// compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow, overflow, zero;
  logic [W-1:0] diff;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] prev_diff;
  logic         prev_borrow, prev_ovf, prev_zero;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow),
    .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: modular difference and flags from plain integer arithmetic.
  function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    int ux, uy, sx, sy, sd;
    logic [W-1:0] d;
    logic bo, ov, z;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= 128) ? ux - 256 : ux;
    sy = (uy >= 128) ? uy - 256 : uy;
    sd = sx - sy;
    d  = W'((ux - uy + 256) % 256);
    bo = (ux < uy);
    ov = (sd > 127) || (sd < -128);
    z  = (d == '0);
    return {bo, ov, z, d};
  endfunction

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_op, input bit inject);
    logic [W+2:0] e;
    e = model(ta, tb_op);
    chk("idle_busy", 32'(busy), 32'd0);
    start = 1'b1; a = ta; b = tb_op;
    tick();
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    for (int k = 0; k <= 8; k++) begin
      chk("busy_run", 32'(busy), 32'd1);
      if (k < 8) begin
        chk("done_early", 32'(done), 32'd0);
        chk("diff_hold", 32'(diff), 32'(prev_diff));
        chk("borrow_hold", 32'(borrow), 32'(prev_borrow));
      end else begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("diff", 32'(diff), 32'(e[W-1:0]));
        chk("borrow", 32'(borrow), 32'(e[W+2]));
        chk("overflow", 32'(overflow), 32'(e[W+1]));
        chk("zero", 32'(zero), 32'(e[W]));
      end
      if (inject && (k == 3 || k == 8)) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk("busy_after", 32'(busy), 32'd0);
    chk("done_after", 32'(done), 32'd0);
    chk("diff_held", 32'(diff), 32'(e[W-1:0]));
    tick();
    chk("done_single", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    prev_diff   = e[W-1:0];
    prev_borrow = e[W+2];
    prev_ovf    = e[W+1];
    prev_zero   = e[W];
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_flags", 32'({borrow, overflow, zero}), 32'd0);
    prev_diff = '0; prev_borrow = 1'b0; prev_ovf = 1'b0; prev_zero = 1'b0;
    tick();

    run_op(8'h05, 8'h03, 1'b0);
    run_op(8'h03, 8'h05, 1'b0);
    run_op(8'h00, 8'h01, 1'b0);
    run_op(8'h80, 8'h01, 1'b0);
    run_op(8'h7F, 8'hFF, 1'b0);
    run_op(8'h2A, 8'h2A, 1'b0);
    run_op(8'h10, 8'h01, 1'b1);
    run_op(8'h33, 8'h00, 1'b0);

    // Reset in the middle of an operation aborts it and clears the outputs.
    start = 1'b1; a = 8'h55; b = 8'h11;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("rst_mid_busy", 32'(busy), 32'd1);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_flags", 32'({borrow, overflow, zero}), 32'd0);
    for (int k = 0; k < 10; k++) begin
      chk("abort_nodone", 32'(done), 32'd0);
      tick();
    end
    prev_diff = '0; prev_borrow = 1'b0; prev_ovf = 1'b0; prev_zero = 1'b0;
    run_op(8'h55, 8'h11, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 8 == 1) rb = ra;
      if (i % 8 == 2) rb = '0;
      run_op(ra, rb, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
